// File: rtl/serial_proto_pkg.sv
// Shared definitions for the serial-to-HBA bridge protocol: framing characters, command
// byte layout, status codes and the initiator frame states. The responder uses the same package.
package serial_proto_pkg;

    localparam logic [7:0] ACK_CHAR  = 8'hAC;
    localparam logic [7:0] NACK_CHAR = 8'h56;

    // Command byte layout: {rnw, num_bytes[2:0], core_addr[3:0]}
    localparam int unsigned RNW_BIT  = 7;
    localparam int unsigned NUM_MSB  = 6;
    localparam int unsigned NUM_LSB  = 4;
    localparam int unsigned CORE_MSB = 3;
    localparam int unsigned CORE_LSB = 0;

    typedef enum logic [1:0] {
        StatusOk      = 2'b00,
        StatusBadAck  = 2'b01,
        StatusEcho    = 2'b10,
        StatusTimeout = 2'b11
    } status_e;

    typedef enum logic [3:0] {
        StIdle,
        StSendCmd,
        StSendRad,
        StSendData,
        StWaitAck,
        StRxEchoCmd,
        StRxEchoRad,
        StRxData,
        StFinish
    } init_state_e;

    function automatic logic [7:0] make_cmd(input logic       rnw,
                                            input logic [2:0] num,
                                            input logic [3:0] core);
        logic [7:0] cmd;
        cmd                    = '0;
        cmd[RNW_BIT]           = rnw;
        cmd[NUM_MSB:NUM_LSB]   = num;
        cmd[CORE_MSB:CORE_LSB] = core;
        return cmd;
    endfunction

endpackage

// File: rtl/serial_hba_initiator_if.sv
// App request port and buart byte port of the serial HBA initiator.
// master: the initiator's view; slave: the app + uart environment's view.
interface serial_hba_initiator_if;

    logic       app_start;
    logic       app_rnw;
    logic [3:0] app_core_addr;
    logic [7:0] app_reg_addr;
    logic [2:0] app_num_bytes;
    logic [7:0] app_wdata;
    logic       app_wdata_valid;
    logic       app_wdata_ready;
    logic [7:0] app_rdata;
    logic       app_rdata_valid;
    logic       app_busy;
    logic       app_done;
    logic [1:0] app_status;
    logic [7:0] uart_tx_data;
    logic       uart_wr;
    logic       uart_tx_busy;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rd;

    modport master (
        input  app_start, app_rnw, app_core_addr, app_reg_addr, app_num_bytes,
        input  app_wdata, app_wdata_valid,
        output app_wdata_ready, app_rdata, app_rdata_valid, app_busy, app_done, app_status,
        output uart_tx_data, uart_wr, uart_rd,
        input  uart_tx_busy, uart_rx_data, uart_rx_valid
    );

    modport slave (
        output app_start, app_rnw, app_core_addr, app_reg_addr, app_num_bytes,
        output app_wdata, app_wdata_valid,
        input  app_wdata_ready, app_rdata, app_rdata_valid, app_busy, app_done, app_status,
        input  uart_tx_data, uart_wr, uart_rd,
        output uart_tx_busy, uart_rx_data, uart_rx_valid
    );

endinterface

// File: rtl/serial_byte_link.sv
// Byte-level handshakes to the buart: one-cycle uart_wr / uart_rd strobes, each followed by a
// guard cycle so the uart's busy/valid flags have time to update before being sampled again.
module serial_byte_link (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_req_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_ready_o,
    output logic       tx_fire_o,
    output logic [7:0] uart_tx_data_o,
    output logic       uart_wr_o,
    input  logic       uart_tx_busy_i,
    input  logic       rx_en_i,
    output logic       rx_fire_o,
    output logic [7:0] rx_byte_o,
    input  logic [7:0] uart_rx_data_i,
    input  logic       uart_rx_valid_i,
    output logic       uart_rd_o
);

    logic tx_guard_q, tx_guard_d;
    logic rx_guard_q, rx_guard_d;

    // Strobe generation and guard-cycle arming.
    always_comb begin
        tx_ready_o     = !uart_tx_busy_i && !tx_guard_q;
        tx_fire_o      = tx_req_i && tx_ready_o;
        uart_wr_o      = tx_fire_o;
        uart_tx_data_o = tx_byte_i;
        rx_fire_o      = rx_en_i && uart_rx_valid_i && !rx_guard_q;
        uart_rd_o      = rx_fire_o;
        rx_byte_o      = uart_rx_data_i;
        tx_guard_d     = tx_fire_o;
        rx_guard_d     = rx_fire_o;
    end

    // Guard flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_guard_q <= 1'b0;
            rx_guard_q <= 1'b0;
        end else begin
            tx_guard_q <= tx_guard_d;
            rx_guard_q <= rx_guard_d;
        end
    end

endmodule

// File: rtl/serial_hba_initiator.sv
// Host end of the serial-to-HBA bridge: frames register read/write transactions as
// cmd/regaddr/data bytes, checks the responder's echo/ACK and returns read data.
// Optional build macro SERIAL_INIT_TIMEOUT_EN adds a per-byte response timeout (status 11).
module serial_hba_initiator
    import serial_proto_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50_000_000,
    parameter int unsigned TIMEOUT_US    = 2000
) (
    input logic                    hba_clk,
    input logic                    hba_reset_n,
    serial_hba_initiator_if.master bus
);

    init_state_e state_q, state_d;
    logic        rnw_q, rnw_d;
    logic [2:0]  num_q, num_d;
    logic [3:0]  core_q, core_d;
    logic [7:0]  reg_q, reg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  status_q, status_d;

    logic       tx_req, tx_ready, tx_fire;
    logic [7:0] tx_byte;
    logic       rx_en, rx_fire;
    logic [7:0] rx_byte;
    logic       wdata_ready;
    logic [7:0] cmd_byte;
    logic       timeout_hit;

    assign cmd_byte = make_cmd(rnw_q, num_q, core_q);

    serial_byte_link u_link (
        .clk_i          (hba_clk),
        .rst_ni         (hba_reset_n),
        .tx_req_i       (tx_req),
        .tx_byte_i      (tx_byte),
        .tx_ready_o     (tx_ready),
        .tx_fire_o      (tx_fire),
        .uart_tx_data_o (bus.uart_tx_data),
        .uart_wr_o      (bus.uart_wr),
        .uart_tx_busy_i (bus.uart_tx_busy),
        .rx_en_i        (rx_en),
        .rx_fire_o      (rx_fire),
        .rx_byte_o      (rx_byte),
        .uart_rx_data_i (bus.uart_rx_data),
        .uart_rx_valid_i(bus.uart_rx_valid),
        .uart_rd_o      (bus.uart_rd)
    );

`ifdef SERIAL_INIT_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = TIMEOUT_US * (CLK_FREQUENCY / 1_000_000);

    logic [31:0] tmr_q, tmr_d;
    logic        waiting;

    // Response timer: restarts on every byte moved, idle outside the frame.
    always_comb begin
        waiting = (state_q != StIdle) && (state_q != StFinish);
        tmr_d   = tmr_q + 32'd1;
        if (!waiting || tx_fire || rx_fire) begin
            tmr_d = '0;
        end
        timeout_hit = waiting && !tx_fire && !rx_fire && (tmr_q >= TimeoutCycles - 1);
    end

    // Timer register.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Per-state byte-link requests; kept apart from next-state to avoid a loop through the link.
    always_comb begin
        tx_req      = 1'b0;
        tx_byte     = '0;
        rx_en       = 1'b0;
        wdata_ready = 1'b0;
        unique case (state_q)
            StIdle:    rx_en = 1'b1; // drain stray bytes
            StSendCmd: begin
                tx_req  = 1'b1;
                tx_byte = cmd_byte;
            end
            StSendRad: begin
                tx_req  = 1'b1;
                tx_byte = reg_q;
            end
            StSendData: begin
                tx_req      = bus.app_wdata_valid;
                tx_byte     = bus.app_wdata;
                wdata_ready = tx_ready;
            end
            StWaitAck, StRxEchoCmd, StRxEchoRad, StRxData: rx_en = 1'b1;
            default: ;
        endcase
    end

    assign bus.app_wdata_ready = wdata_ready;
    assign bus.app_rdata_valid = (state_q == StRxData) && rx_fire;
    assign bus.app_rdata       = bus.app_rdata_valid ? rx_byte : 8'h00;
    assign bus.app_busy        = (state_q != StIdle);
    assign bus.app_done        = (state_q == StFinish);
    assign bus.app_status      = status_q;

    // Frame FSM next-state, request latching, byte counting and status.
    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        num_d    = num_q;
        core_d   = core_q;
        reg_d    = reg_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        unique case (state_q)
            StIdle: begin
                if (bus.app_start) begin
                    rnw_d    = bus.app_rnw;
                    num_d    = bus.app_num_bytes;
                    core_d   = bus.app_core_addr;
                    reg_d    = bus.app_reg_addr;
                    cnt_d    = '0;
                    status_d = StatusOk;
                    state_d  = StSendCmd;
                end
            end
            StSendCmd: if (tx_fire) state_d = StSendRad;
            StSendRad: if (tx_fire) state_d = rnw_q ? StRxEchoCmd : StSendData;
            StSendData: begin
                if (tx_fire) begin
                    if (cnt_q == num_q) begin
                        cnt_d   = '0;
                        state_d = StWaitAck;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StWaitAck: begin
                if (rx_fire) begin
                    status_d = (rx_byte == ACK_CHAR) ? StatusOk : StatusBadAck;
                    state_d  = StFinish;
                end
            end
            StRxEchoCmd: begin
                if (rx_fire) begin
                    if (rx_byte != cmd_byte) begin
                        status_d = StatusEcho;
                        state_d  = StFinish;
                    end else begin
                        state_d = StRxEchoRad;
                    end
                end
            end
            StRxEchoRad: begin
                if (rx_fire) begin
                    if (rx_byte != reg_q) begin
                        status_d = StatusEcho;
                        state_d  = StFinish;
                    end else begin
                        state_d = StRxData;
                    end
                end
            end
            StRxData: begin
                if (rx_fire) begin
                    if (cnt_q == num_q) begin
                        cnt_d   = '0;
                        state_d = StFinish;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout_hit) begin
            status_d = StatusTimeout;
            state_d  = StFinish;
        end
    end

    // Frame state and latched request fields.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state_q  <= StIdle;
            rnw_q    <= 1'b0;
            num_q    <= '0;
            core_q   <= '0;
            reg_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            rnw_q    <= rnw_d;
            num_q    <= num_d;
            core_q   <= core_d;
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_serial_hba_initiator.sv
// Directed bench for serial_hba_initiator: the bench plays app, buart and responder.
// Build with SERIAL_INIT_TIMEOUT_EN to exercise the timeout path (20-cycle limit here).
module tb_serial_hba_initiator;

    logic hba_clk;
    logic hba_reset_n;

    serial_hba_initiator_if bus();

    serial_hba_initiator #(
        .CLK_FREQUENCY(1_000_000),
        .TIMEOUT_US   (20)
    ) dut (
        .hba_clk    (hba_clk),
        .hba_reset_n(hba_reset_n),
        .bus        (bus.master)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] txq[$];
    logic [7:0] rdq[$];
    logic [7:0] wq[$];

    initial begin
        hba_clk = 1'b0;
        forever #5 hba_clk = ~hba_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Observe outputs just before each posedge; feed write data after each posedge.
    initial begin
        bit pop;
        bus.app_wdata_valid = 1'b0;
        bus.app_wdata       = 8'h00;
        forever begin
            @(negedge hba_clk);
            #2;
            if (bus.uart_wr) txq.push_back(bus.uart_tx_data);
            if (bus.app_rdata_valid) rdq.push_back(bus.app_rdata);
            if (bus.app_done) done_cnt++;
            pop = bus.app_wdata_valid && bus.app_wdata_ready;
            @(posedge hba_clk);
            #1;
            if (pop && wq.size() > 0) void'(wq.pop_front());
            bus.app_wdata_valid = (wq.size() != 0);
            bus.app_wdata       = (wq.size() != 0) ? wq[0] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic rnw, input logic [3:0] core, input logic [7:0] ra,
                             input logic [2:0] num);
        @(negedge hba_clk);
        bus.app_rnw       = rnw;
        bus.app_core_addr = core;
        bus.app_reg_addr  = ra;
        bus.app_num_bytes = num;
        bus.app_start     = 1'b1;
        @(negedge hba_clk);
        bus.app_start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input string tag);
        bit got;
        got = 1'b0;
        @(negedge hba_clk);
        bus.uart_rx_data  = b;
        bus.uart_rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #2;
            got = bus.uart_rd;
            @(posedge hba_clk);
            #1;
            if (got) break;
            @(negedge hba_clk);
        end
        bus.uart_rx_valid = 1'b0;
        chk({tag, " rx consumed"}, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_tx(input int n, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge hba_clk);
            #1;
            if (txq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " tx count"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input int bound, input string tag);
        bit ok;
        int start;
        ok    = 1'b0;
        start = done_cnt;
        for (int i = 0; i < bound; i++) begin
            @(posedge hba_clk);
            #1;
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " done"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge hba_clk);
        hba_reset_n       = 1'b0;
        bus.app_start     = 1'b0;
        bus.uart_rx_valid = 1'b0;
        bus.uart_tx_busy  = 1'b0;
        wq.delete();
        repeat (2) @(negedge hba_clk);
        hba_reset_n = 1'b1;
        txq.delete();
        rdq.delete();
    endtask

    initial begin
        int d0;
        hba_reset_n       = 1'b0;
        bus.app_start     = 1'b0;
        bus.app_rnw       = 1'b0;
        bus.app_core_addr = 4'h0;
        bus.app_reg_addr  = 8'h00;
        bus.app_num_bytes = 3'd0;
        bus.uart_tx_busy  = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge hba_clk);
        #2;
        chk("rst busy", {31'd0, bus.app_busy}, 32'd0);
        chk("rst done", {31'd0, bus.app_done}, 32'd0);
        chk("rst status", {30'd0, bus.app_status}, 32'd0);
        chk("rst uart_wr", {31'd0, bus.uart_wr}, 32'd0);
        chk("rst uart_rd", {31'd0, bus.uart_rd}, 32'd0);
        chk("rst wready", {31'd0, bus.app_wdata_ready}, 32'd0);
        chk("rst txdata", {24'd0, bus.uart_tx_data}, 32'd0);
        @(negedge hba_clk);
        hba_reset_n = 1'b1;

        // 1: write core 2, reg 0x10, one byte 0x5A, ACK; start while busy is ignored
        wq.push_back(8'h5A);
        start_txn(1'b0, 4'h2, 8'h10, 3'd0);
        wait_tx(3, "t1");
        chk("t1 cmd", {24'd0, txq[0]}, 32'h02);
        chk("t1 rad", {24'd0, txq[1]}, 32'h10);
        chk("t1 data", {24'd0, txq[2]}, 32'h5A);
        chk("t1 busy", {31'd0, bus.app_busy}, 32'd1);
        start_txn(1'b1, 4'h7, 8'hEE, 3'd5);
        send_rx(8'hAC, "t1 ack");
        wait_done(50, "t1");
        chk("t1 status", {30'd0, bus.app_status}, 32'd0);
        repeat (4) @(negedge hba_clk);
        #2;
        chk("t1 idle busy", {31'd0, bus.app_busy}, 32'd0);
        chk("t1 no extra tx", txq.size(), 32'd3);
        chk("t1 one done", done_cnt, 32'd1);

        // 2: read core 3, reg 0x20, 4 bytes; tx held off by uart_tx_busy first
        txq.delete();
        rdq.delete();
        bus.uart_tx_busy = 1'b1;
        start_txn(1'b1, 4'h3, 8'h20, 3'd3);
        repeat (5) @(negedge hba_clk);
        chk("t2 held by busy", txq.size(), 32'd0);
        bus.uart_tx_busy = 1'b0;
        wait_tx(2, "t2");
        chk("t2 cmd", {24'd0, txq[0]}, 32'hB3);
        chk("t2 rad", {24'd0, txq[1]}, 32'h20);
        send_rx(8'hB3, "t2 echo cmd");
        send_rx(8'h20, "t2 echo rad");
        send_rx(8'h11, "t2 d0");
        send_rx(8'h22, "t2 d1");
        send_rx(8'h33, "t2 d2");
        send_rx(8'h44, "t2 d3");
        wait_done(50, "t2");
        chk("t2 status", {30'd0, bus.app_status}, 32'd0);
        chk("t2 rdata count", rdq.size(), 32'd4);
        chk("t2 rdata0", {24'd0, rdq[0]}, 32'h11);
        chk("t2 rdata3", {24'd0, rdq[3]}, 32'h44);

        // 3: write answered with NACK
        txq.delete();
        wq.push_back(8'h77);
        start_txn(1'b0, 4'h1, 8'h05, 3'd0);
        wait_tx(3, "t3");
        chk("t3 cmd", {24'd0, txq[0]}, 32'h01);
        send_rx(8'h56, "t3 nack");
        wait_done(50, "t3");
        chk("t3 status", {30'd0, bus.app_status}, 32'd1);
        chk("t3 busy", {31'd0, bus.app_busy}, 32'd0);

        // 4: corrupted echo, trailing bytes drained in idle, then a clean read
        txq.delete();
        rdq.delete();
        start_txn(1'b1, 4'h3, 8'h20, 3'd3);
        wait_tx(2, "t4");
        send_rx(8'hB2, "t4 bad echo");
        wait_done(50, "t4");
        chk("t4 status", {30'd0, bus.app_status}, 32'd2);
        send_rx(8'h20, "t4 drain0");
        send_rx(8'h11, "t4 drain1");
        send_rx(8'h22, "t4 drain2");
        chk("t4 no rdata", rdq.size(), 32'd0);
        chk("t4 idle", {31'd0, bus.app_busy}, 32'd0);
        chk("t4 status held", {30'd0, bus.app_status}, 32'd2);
        txq.delete();
        start_txn(1'b1, 4'h3, 8'h20, 3'd3);
        wait_tx(2, "t4b");
        send_rx(8'hB3, "t4b echo cmd");
        send_rx(8'h20, "t4b echo rad");
        send_rx(8'hA1, "t4b d0");
        send_rx(8'hA2, "t4b d1");
        send_rx(8'hA3, "t4b d2");
        send_rx(8'hA4, "t4b d3");
        wait_done(50, "t4b");
        chk("t4b status", {30'd0, bus.app_status}, 32'd0);
        chk("t4b rdata count", rdq.size(), 32'd4);
        chk("t4b rdata0", {24'd0, rdq[0]}, 32'hA1);
        chk("t4b rdata3", {24'd0, rdq[3]}, 32'hA4);

        // 5: responder silent after regaddr
        txq.delete();
        start_txn(1'b1, 4'h4, 8'h30, 3'd0);
        wait_tx(2, "t5");
        chk("t5 cmd", {24'd0, txq[0]}, 32'h84);
`ifdef SERIAL_INIT_TIMEOUT_EN
        wait_done(40, "t5 timeout");
        chk("t5 status", {30'd0, bus.app_status}, 32'd3);
`else
        d0 = done_cnt;
        repeat (100) @(negedge hba_clk);
        chk("t5 still busy", {31'd0, bus.app_busy}, 32'd1);
        chk("t5 no done", done_cnt, d0);
`endif
        do_reset();

        // 6: reset in the middle of SEND_DATA
        wq.push_back(8'h99);
        start_txn(1'b0, 4'h1, 8'h40, 3'd3);
        wait_tx(3, "t6");
        chk("t6 cmd", {24'd0, txq[0]}, 32'h31);
        chk("t6 data", {24'd0, txq[2]}, 32'h99);
        repeat (2) @(negedge hba_clk);
        #2;
        chk("t6 wready", {31'd0, bus.app_wdata_ready}, 32'd1);
        d0 = done_cnt;
        hba_reset_n = 1'b0;
        #1;
        chk("t6 rst busy", {31'd0, bus.app_busy}, 32'd0);
        chk("t6 rst wready", {31'd0, bus.app_wdata_ready}, 32'd0);
        chk("t6 rst uart_wr", {31'd0, bus.uart_wr}, 32'd0);
        chk("t6 rst status", {30'd0, bus.app_status}, 32'd0);
        repeat (3) @(negedge hba_clk);
        hba_reset_n = 1'b1;
        repeat (3) @(negedge hba_clk);
        chk("t6 no done", done_cnt, d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
